// File: rtl/concat_n_pkg.sv
// Shared types and helpers for the N-way list-stream concatenator.
// Contents: state enum st_e, element counter width COUNT_W, sel_width()
// which gives the width of a list index for n lists.
package concat_pkg;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } st_e;

    localparam int unsigned COUNT_W = 16;

    // Width of an index over n lists; a single list still needs one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        int unsigned r;
        r = 1;
        if (n > 1) begin
            r = $clog2(n);
        end
        return r;
    endfunction

endpackage : concat_pkg

// File: rtl/concat_n_list_sel_mux.sv
// list_sel_mux: combinational routing between the consumer side and the
// currently selected source list.
// Ports:
//   sel              in   SEL_W  index of the selected list
//   en               in   1      allow the consumer request through to a source
//   req              in   1      consumer request
//   list_ack         in   N      per-list acknowledge
//   list_value       in   N*W    list i at bits [i*W +: W]
//   list_value_valid in   N      per-list element/end flag
//   list_req         out  N      one-hot (or zero) request to the selected list
//   sel_value        out  W      value of the selected list
//   sel_valid        out  1      value_valid of the selected list
//   sel_ack          out  1      acknowledge of the selected list
module list_sel_mux #(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned SEL_W = 2
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    input  logic             req,
    input  logic [N-1:0]     list_ack,
    input  logic [N*W-1:0]   list_value,
    input  logic [N-1:0]     list_value_valid,
    output logic [N-1:0]     list_req,
    output logic [W-1:0]     sel_value,
    output logic             sel_valid,
    output logic             sel_ack
);

    // Loop compare instead of a direct index so a sel beyond N-1 selects nothing.
    always_comb begin
        list_req  = '0;
        sel_value = '0;
        sel_valid = 1'b0;
        sel_ack   = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (SEL_W'(i) == sel) begin
                list_req[i] = en & req;
                sel_value   = list_value[i*W +: W];
                sel_valid   = list_value_valid[i];
                sel_ack     = list_ack[i];
            end
        end
    end

endmodule : list_sel_mux

// File: rtl/concat_n.sv
// concat_n: concatenates N source list streams into one consumer stream.
// Pulls list 0 to its end, then list 1, ... list N-1. Intermediate end
// markers are swallowed (one bubble cycle each); only the last one is
// forwarded, after which every request is answered with an end marker.
// Optional: define CONCAT_N_COUNT_EN to add a saturating element counter.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   ready                 0 = re-arm to list 0 on the next edge
//   list_req/ack/value/value_valid   source-side streams (N lanes)
//   req/ack/value/value_valid        consumer-side stream
//   cur_list              index of the selected list
//   count (optional)      elements delivered since reset / re-arm
module concat_n
    import concat_pkg::*;
#(
    parameter  int unsigned N     = 4,
    parameter  int unsigned W     = 8,
    localparam int unsigned SEL_W = sel_width(N)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ready,
    output logic [N-1:0]       list_req,
    input  logic [N-1:0]       list_ack,
    input  logic [N*W-1:0]     list_value,
    input  logic [N-1:0]       list_value_valid,
    input  logic               req,
    output logic               ack,
    output logic [W-1:0]       value,
    output logic               value_valid,
`ifdef CONCAT_N_COUNT_EN
    output logic [COUNT_W-1:0] count,
`endif
    output logic [SEL_W-1:0]   cur_list
);

    st_e              st_q, st_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             route_en;
    logic [W-1:0]     mux_value;
    logic             mux_valid;
    logic             mux_ack;
    logic             is_last;

    assign is_last  = (sel_q == SEL_W'(N - 1));
    assign cur_list = sel_q;

    list_sel_mux #(
        .N     (N),
        .W     (W),
        .SEL_W (SEL_W)
    ) u_mux (
        .sel              (sel_q),
        .en               (route_en),
        .req              (req),
        .list_ack         (list_ack),
        .list_value       (list_value),
        .list_value_valid (list_value_valid),
        .list_req         (list_req),
        .sel_value        (mux_value),
        .sel_valid        (mux_valid),
        .sel_ack          (mux_ack)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            st_q  <= S_RUN;
            sel_q <= '0;
        end else begin
            st_q  <= st_d;
            sel_q <= sel_d;
        end
    end

    // Next state and consumer-side outputs; ready=0 overrides any advance.
    always_comb begin
        st_d        = st_q;
        sel_d       = sel_q;
        route_en    = 1'b0;
        ack         = 1'b0;
        value       = '0;
        value_valid = 1'b0;
        if (!reset) begin
            case (st_q)
                S_RUN: begin
                    route_en    = 1'b1;
                    value       = mux_value;
                    value_valid = mux_valid;
                    if (mux_ack) begin
                        if (mux_valid) begin
                            ack = 1'b1;
                        end else if (is_last) begin
                            ack  = 1'b1;
                            st_d = S_DONE;
                        end else begin
                            sel_d = sel_q + SEL_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    ack = req;
                end
                default: begin
                    st_d = S_RUN;
                end
            endcase
            if (!ready) begin
                sel_d = '0;
                st_d  = S_RUN;
            end
        end
    end

`ifdef CONCAT_N_COUNT_EN
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    assign count = cnt_q;

    // Saturating count of delivered elements; cleared on re-arm.
    always_comb begin
        cnt_d = cnt_q;
        if (ack && value_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + COUNT_W'(1);
        end
        if (!ready) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule : concat_n

// File: tb/tb_concat_n.sv
// Directed bench for concat_n with N=3, W=8.
module tb_concat_n;

    localparam int unsigned N = 3;
    localparam int unsigned W = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          ready;
    logic [N-1:0]  list_req;
    logic [N-1:0]  list_ack;
    logic [N*W-1:0] list_value;
    logic [N-1:0]  list_value_valid;
    logic          req;
    logic          ack;
    logic [W-1:0]  value;
    logic          value_valid;
    logic [1:0]    cur_list;
`ifdef CONCAT_N_COUNT_EN
    logic [15:0]   count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int bubbles = 0;

    concat_n #(.N(N), .W(W)) dut (
        .clock            (clock),
        .reset            (reset),
        .ready            (ready),
        .list_req         (list_req),
        .list_ack         (list_ack),
        .list_value       (list_value),
        .list_value_valid (list_value_valid),
        .req              (req),
        .ack              (ack),
        .value            (value),
        .value_valid      (value_valid),
`ifdef CONCAT_N_COUNT_EN
        .count            (count),
`endif
        .cur_list         (cur_list)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, let them settle.
    task automatic apply(input logic rdy, input logic rq, input logic [2:0] la,
                         input logic [23:0] lv, input logic [2:0] lvv);
        @(posedge clock);
        #1;
        ready            = rdy;
        req              = rq;
        list_ack         = la;
        list_value       = lv;
        list_value_valid = lvv;
        #1;
    endtask

    task automatic expect_outs(input string tag, input logic [2:0] lr, input logic a,
                               input logic vv, input logic [1:0] cl);
        check({tag, ".list_req"}, 32'(list_req), 32'(lr));
        check({tag, ".ack"}, 32'(ack), 32'(a));
        check({tag, ".value_valid"}, 32'(value_valid), 32'(vv));
        check({tag, ".cur_list"}, 32'(cur_list), 32'(cl));
    endtask

    initial begin
        reset = 1'b1; ready = 1'b1; req = 1'b1;
        list_ack = '0; list_value = 24'h112233; list_value_valid = '1;
        @(posedge clock); #2;
        expect_outs("rst", 3'b000, 1'b0, 1'b0, 2'd0);
        check("rst.value", 32'(value), 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Scenario 1: list0={01,02}, list1={}, list2={07}
        apply(1, 1, 3'b000, 24'h0, 3'b000); expect_outs("s1.c0", 3'b001, 0, 0, 0);
        apply(1, 1, 3'b001, 24'h000001, 3'b001); expect_outs("s1.e01", 3'b001, 1, 1, 0);
        check("s1.v01", 32'(value), 32'h01);
        apply(1, 1, 3'b000, 24'h0, 3'b000); expect_outs("s1.c2", 3'b001, 0, 0, 0);
        apply(1, 1, 3'b001, 24'h000002, 3'b001); expect_outs("s1.e02", 3'b001, 1, 1, 0);
        check("s1.v02", 32'(value), 32'h02);
        apply(1, 1, 3'b000, 24'h0, 3'b000);
        apply(1, 1, 3'b001, 24'h0, 3'b000); expect_outs("s1.end0", 3'b001, 0, 0, 0);
        if (!ack && list_ack != 0) bubbles++;
        apply(1, 1, 3'b000, 24'h0, 3'b000); expect_outs("s1.l1", 3'b010, 0, 0, 1);
        apply(1, 1, 3'b010, 24'h0, 3'b000); expect_outs("s1.end1", 3'b010, 0, 0, 1);
        if (!ack && list_ack != 0) bubbles++;
        apply(1, 1, 3'b000, 24'h0, 3'b000); expect_outs("s1.l2", 3'b100, 0, 0, 2);
        apply(1, 1, 3'b100, 24'h070000, 3'b100); expect_outs("s1.e07", 3'b100, 1, 1, 2);
        check("s1.v07", 32'(value), 32'h07);
        if (!ack && list_ack != 0) bubbles++;
        apply(1, 1, 3'b000, 24'h0, 3'b000);
        apply(1, 1, 3'b100, 24'h0, 3'b000); expect_outs("s1.final", 3'b100, 1, 0, 2);
        check("s1.bubbles", 32'(bubbles), 32'd2);

        // Done state: repeated end markers, sources untouched
        for (int k = 0; k < 3; k++) begin
            apply(1, 1, 3'b111, 24'hAABBCC, 3'b111);
            expect_outs("done.req", 3'b000, 1, 0, 2);
            check("done.value", 32'(value), 32'h0);
`ifdef CONCAT_N_COUNT_EN
            check("cnt.after", 32'(count), 32'd3);
`endif
            apply(1, 0, 3'b000, 24'h0, 3'b000);
            check("done.idle_ack", 32'(ack), 32'h0);
        end

        // Reset while in S_DONE with req held
        @(posedge clock); #1;
        reset = 1'b1; req = 1'b1; #1;
        expect_outs("rst2", 3'b000, 0, 0, 2);
        @(posedge clock); #1;
        reset = 1'b0; #1;
        expect_outs("rst2.rel", 3'b001, 0, 0, 0);

        // Re-arm while list1 is mid-element
        apply(1, 1, 3'b001, 24'h0, 3'b000); expect_outs("ra.end0", 3'b001, 0, 0, 0);
        apply(1, 1, 3'b000, 24'h0, 3'b000); expect_outs("ra.l1", 3'b010, 0, 0, 1);
        apply(0, 1, 3'b010, 24'h003300, 3'b010); expect_outs("ra.mid", 3'b010, 1, 1, 1);
        check("ra.v33", 32'(value), 32'h33);
        apply(1, 1, 3'b001, 24'h000001, 3'b001); expect_outs("ra.replay", 3'b001, 1, 1, 0);
        check("ra.v01", 32'(value), 32'h01);
`ifdef CONCAT_N_COUNT_EN
        check("cnt.clr", 32'(count), 32'd0);
`endif

        // ready=0 beats an end-marker advance; spurious unselected ack ignored
        apply(0, 1, 3'b001, 24'h0, 3'b000); expect_outs("pr.end0", 3'b001, 0, 0, 0);
        apply(1, 1, 3'b100, 24'h550000, 3'b100); expect_outs("pr.spur", 3'b001, 0, 0, 0);
        apply(1, 1, 3'b001, 24'h0, 3'b000);
        apply(1, 1, 3'b010, 24'h0, 3'b000);
        apply(0, 1, 3'b100, 24'h0, 3'b000); expect_outs("pr.final", 3'b100, 1, 0, 2);
        apply(1, 1, 3'b000, 24'h0, 3'b000); expect_outs("pr.run", 3'b001, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_concat_n

// File: doc/concat_n.md
Name: concat_n

Overview:
- N-way, W-bit generalisation of the two-list stream concatenator.
- Presents one list-stream consumer port; pulls list 0 to its end, then list 1, and so on through list N-1.
- Forwards only the final end marker to the consumer.
- Sits between list producers (filters, generators) and any list consumer in the same req/ack/value/value_valid stream fabric.

Parameters:
- N, 4, number of source lists (>=1)
- W, 8, element width in bits
- SEL_W, (N>1 ? $clog2(N) : 1), width of list index (derived localparam, not overridable)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ready  in  1  0 = re-arm to list 0 on next edge (same meaning as existing blocks)
- list_req  out  N  per-list request; at most one bit set
- list_ack  in  N  per-list acknowledge, single-cycle pulse
- list_value  in  N*W  list i occupies bits [i*W +: W]
- list_value_valid  in  N  with ack: 1 = element, 0 = end of list
- req  in  1  consumer request, held until ack
- ack  out  1  consumer acknowledge, single-cycle
- value  out  W  element to consumer
- value_valid  out  1  with ack: 1 = element, 0 = end of concatenation
- cur_list  out  SEL_W  index of the list currently selected

Behaviour:
- State: sel (SEL_W) and st in {S_RUN, S_DONE}.
- Reset values: sel=0, st=S_RUN, cur_list=0.
- While reset=1: list_req=0, ack=0, value=0, value_valid=0.
- S_RUN, routing is combinational (zero latency):
  - list_req[sel]=req; all other list_req bits 0.
  - value=list_value[sel], value_valid=list_value_valid[sel].
- S_RUN, element (list_ack[sel]=1, valid=1): ack=1; state unchanged.
- S_RUN, end marker with sel<N-1:
  - Marker is swallowed: ack=0 that cycle.
  - sel<=sel+1 at the edge; the consumer keeps req high.
  - Cost: exactly one bubble cycle per list boundary. An empty list costs one cycle.
- S_RUN, end marker with sel==N-1: forwarded (ack=1, value_valid=0); st<=S_DONE.
- S_DONE:
  - All list_req=0.
  - req=1 gives ack=1, value_valid=0, value=0 in the same cycle, repeatedly, sources untouched.
- ready=0: sel<=0 and st<=S_RUN at the edge; combinational routing that cycle is unaffected.
- ready=0 takes priority over a same-cycle end-marker advance or a same-cycle transition to S_DONE.
- Re-arm or reset mid-list abandons any in-flight source request. Sources must tolerate req withdrawal.
- list_ack on an unselected list is ignored.
- cur_list mirrors sel.
- N=1: degenerates to a pass-through plus S_DONE latch.

Optional Feature:
- Macro CONCAT_N_COUNT_EN.
- Defined:
  - Adds output count [15:0], reset 0.
  - Increments on each cycle with ack=1 and value_valid=1 to the consumer; saturates at 16'hFFFF.
  - Cleared to 0 on the edge where ready=0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package concat_pkg:
  - st_e enum {S_RUN, S_DONE}
  - function sel_width(n) returning n>1 ? $clog2(n) : 1
  - COUNT_W=16
- One natural sub-module, list_sel_mux:
  - Parametrised N, W.
  - Combinational one-hot req demux plus value/value_valid/ack mux indexed by sel.
  - Instantiated once.

Test Plan:
- Concatenation with boundary bubbles:
  - Setup: N=3, W=8; list0={8'h01,8'h02}, list1={} (empty), list2={8'h07}; req held high, sources ack next cycle.
  - Response: consumer receives 01, 02, 07, then end marker.
  - Bubbles: exactly two non-ack boundary cycles (after list0 end, after list1 end); cur_list steps 0->1->2.
- Done state holds:
  - Stimulus: after the final end marker, issue 3 more req pulses.
  - Response: each acked same cycle with value_valid=0; list_req stays 3'b000.
- Re-arm mid-list:
  - Stimulus: ready=0 for one cycle while sel=1 mid-element.
  - Response: cur_list=0 next cycle; the following req routes to list_req[0]; list0 replays from its first element.
- Reset mid-operation:
  - Stimulus: reset=1 during S_DONE with req=1.
  - Response: ack=0 and list_req=0 during reset; after release, st=S_RUN, sel=0, first req goes to list 0.
- Priority and ignored acks:
  - Stimulus: ready=0 in the same cycle as list0's end marker; separately, a spurious list_ack[2] while sel=0.
  - Response: sel stays 0 after the end marker (ready wins); the spurious ack produces no consumer ack.
- Counter (CONCAT_N_COUNT_EN):
  - Stimulus: the first scenario's stimulus.
  - Response: count=3 after the end marker; count=0 after one ready=0 cycle.
  - Forced start at 16'hFFFE: count saturates at 16'hFFFF.
